ysyx_22040895_divider: RTL

Iterative radix-2 integer divider implementing RV64M DIV/DIVU/REM/REMU and their W variants. It sits in the execute stage beside the ALU. Its result is muxed onto the execute-result bus that feeds the memory-access stage as the ALU result / write-back value. The core holds the pipeline while `busy_o` is high and captures the result on the single-cycle `result_valid_o` pulse.

---
 rtl/ysyx_22040895_divider_if.sv | 31 +++
 rtl/ysyx_22040895_divider.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// Latency: none (wires only).
// Backpressure: div_ready_o gates requests; results are a one-cycle pulse with no stall.
// Ports: div_valid_i/div_ready_o request handshake, div_op_i/div_word_i opcode,
//        dividend_i/divisor_i operands, flush_i abort, busy_o, result_valid_o/result_o.
interface ysyx_22040895_divider_if #(
  parameter int XLEN = 64
);
  logic            div_valid_i;
  logic            div_ready_o;
  logic [1:0]      div_op_i;
  logic            div_word_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            flush_i;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  // Core side: issues requests, consumes the result.
  modport master (
    output div_valid_i, div_op_i, div_word_i, dividend_i, divisor_i, flush_i,
    input  div_ready_o, busy_o, result_valid_o, result_o
  );

  // Divider side.
  modport slave (
    input  div_valid_i, div_op_i, div_word_i, dividend_i, divisor_i, flush_i,
    output div_ready_o, busy_o, result_valid_o, result_o
  );
endinterface

// File: rtl/ysyx_22040895_divider.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Latency: N+1 cycles incl. accept (65 / 33 for W); div-by-zero and overflow 1 cycle.
// Backpressure: accepts only in IDLE; result pulse has no backpressure, flush aborts.
// Ports: clk, rst (async active-low), bus (slave modport of ysyx_22040895_divider_if).
module ysyx_22040895_divider #(
  parameter int XLEN = 64
) (
  input  logic clk,
  input  logic rst,
  ysyx_22040895_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [6:0]      cnt;
  logic [XLEN-1:0] rem_q, dvd_q, dsr_q, result_q;
  logic [1:0]      op_q;
  logic            word_q, sa_q, sb_q;

  // ---------------- operand preparation (accept cycle) ----------------
  logic            accept, signed_op, w;
  logic            a_sign, b_sign, a_neg, b_neg;
  logic [XLEN-1:0] a, b, a_ext, b_ext, a_mag, b_mag, spec_res;
  logic            div_zero, ovf, special;

  assign a         = bus.dividend_i;
  assign b         = bus.divisor_i;
  assign w         = bus.div_word_i;
  assign signed_op = ~bus.div_op_i[0];
  assign accept    = bus.div_valid_i && (state == IDLE) && !bus.flush_i;

  assign a_sign = w ? a[31] : a[XLEN-1];
  assign b_sign = w ? b[31] : b[XLEN-1];
  assign a_neg  = signed_op & a_sign;
  assign b_neg  = signed_op & b_sign;

  // Word operands are extended by their effective sign so that negating the
  // 64-bit value yields the 32-bit magnitude with zero upper bits.
  assign a_ext = w ? {{(XLEN-32){a_neg}}, a[31:0]} : a;
  assign b_ext = w ? {{(XLEN-32){b_neg}}, b[31:0]} : b;
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  assign div_zero = w ? (b[31:0] == 32'd0) : (b == '0);
  assign ovf      = signed_op &
                    (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
  assign special  = div_zero | ovf;

  always_comb begin
    spec_res = '0;
    if (div_zero) spec_res = bus.div_op_i[1] ? a : '1;
    else          spec_res = bus.div_op_i[1] ? '0 : a;
    if (w) spec_res = {{(XLEN-32){spec_res[31]}}, spec_res[31:0]};
  end

  // ---------------- one restoring step per CALC cycle ----------------
  logic [XLEN:0]   shifted, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, dvd_nxt;

  assign shifted = {rem_q, dvd_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_q};
  // shifted < 2*divisor, so the borrow bit alone decides remainder >= divisor.
  assign ge      = ~diff[XLEN];
  assign rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  // Quotient bits enter at the LSB as dividend bits leave at the MSB.
  assign dvd_nxt = {dvd_q[XLEN-2:0], ge};

  // ---------------- sign fix-up on the final step ----------------
  logic [XLEN-1:0] quo_raw, quo_fix, rem_fix, fin_res;
  logic [6:0]      cnt_last;

  assign cnt_last = word_q ? 7'd31 : 7'(XLEN-1);
  assign quo_raw  = word_q ? {{(XLEN-32){1'b0}}, dvd_nxt[31:0]} : dvd_nxt;
  assign quo_fix  = (~op_q[0] & (sa_q ^ sb_q)) ? -quo_raw : quo_raw;
  assign rem_fix  = (~op_q[0] & sa_q) ? -rem_nxt : rem_nxt;

  always_comb begin
    fin_res = op_q[1] ? rem_fix : quo_fix;
    if (word_q) fin_res = {{(XLEN-32){fin_res[31]}}, fin_res[31:0]};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == cnt_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) state_nxt = IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else if (accept) begin
      op_q   <= bus.div_op_i;
      word_q <= w;
      sa_q   <= a_sign;
      sb_q   <= b_sign;
      cnt    <= '0;
      rem_q  <= '0;
      // Word dividends are left-aligned so the MSB-first shift sees bit 31 first.
      dvd_q  <= w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
      dsr_q  <= b_mag;
      if (special) result_q <= spec_res;
    end else if (state == CALC && !bus.flush_i) begin
      rem_q <= rem_nxt;
      dvd_q <= dvd_nxt;
      cnt   <= cnt + 7'd1;
      if (cnt == cnt_last) result_q <= fin_res;
    end
  end

  assign bus.div_ready_o    = (state == IDLE);
  assign bus.busy_o         = (state == CALC) || (state == DONE);
  assign bus.result_valid_o = (state == DONE);
  assign bus.result_o       = result_q;

endmodule
